// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding instruction fetch and decode handshake with branch redirect.
// Define IF_BUFFER_EN for a 2-entry instruction FIFO in front of decode.
module fetch_stage #(
   parameter logic [17:0] RESET_PC = 18'h00000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_if_branch,
   input  logic [17:0] ex_if_target,
   input  logic        id_if_stall,
   output logic        if_mc_en,
   output logic [17:0] if_mc_addr,
   input  logic [31:0] mc_if_data,
   input  logic        mc_if_valid,
   output logic        if_id_valid,
   output logic [31:0] if_id_instruc,
   output logic [17:0] if_id_pc
);
   logic [17:0] tgt;
   logic        en_q;
   logic        discard_q;
   logic [17:0] addr_q;
   logic [17:0] pc_q;

   assign tgt        = ex_if_target & ~18'h3;
   assign if_mc_en   = en_q;
   assign if_mc_addr = addr_q;

`ifdef IF_BUFFER_EN
   logic [1:0]  cnt_q;
   logic        head_q;
   logic [31:0] instr_q [2];
   logic [17:0] ipc_q [2];
   logic        push;
   logic        pop;
   logic        held;
   logic        issue;
   logic [1:0]  cnt_d;
   logic [17:0] nxt_pc;

   assign push   = en_q & mc_if_valid & ~discard_q;
   assign pop    = (cnt_q != 2'd0) & ~id_if_stall;
   assign held   = en_q & ~mc_if_valid;
   assign cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
   assign nxt_pc = push ? addr_q + 18'd4 : pc_q;
   // outstanding request already counted by held, so a free slot after this cycle allows a new one
   assign issue  = ~held & (cnt_d != 2'd2);

   assign if_id_valid   = cnt_q != 2'd0;
   assign if_id_instruc = instr_q[head_q];
   assign if_id_pc      = ipc_q[head_q];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en_q       <= 1'b0;
         discard_q  <= 1'b0;
         addr_q     <= RESET_PC;
         pc_q       <= RESET_PC;
         cnt_q      <= 2'd0;
         head_q     <= 1'b0;
         instr_q[0] <= 32'd0;
         instr_q[1] <= 32'd0;
         ipc_q[0]   <= 18'd0;
         ipc_q[1]   <= 18'd0;
      end else if (ex_if_branch) begin
         cnt_q <= 2'd0;
         pc_q  <= tgt;
         if (held) begin
            discard_q <= 1'b1;
         end else begin
            discard_q <= 1'b0;
            en_q      <= 1'b1;
            addr_q    <= tgt;
         end
      end else begin
         if (push) begin
            instr_q[head_q ^ cnt_q[0]] <= mc_if_data;
            ipc_q[head_q ^ cnt_q[0]]   <= addr_q;
         end
         if (pop) head_q <= ~head_q;
         if (en_q & mc_if_valid & discard_q) discard_q <= 1'b0;
         cnt_q <= cnt_d;
         pc_q  <= nxt_pc;
         en_q  <= held | issue;
         if (issue) addr_q <= nxt_pc;
      end
   end
`else
   typedef enum logic [1:0] {IDLE, REQ, WAIT_ID} state_t;
   state_t      state_q;
   logic        valid_q;
   logic [31:0] instr_q;
   logic [17:0] id_pc_q;

   assign if_id_valid   = valid_q;
   assign if_id_instruc = instr_q;
   assign if_id_pc      = id_pc_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         en_q      <= 1'b0;
         discard_q <= 1'b0;
         addr_q    <= RESET_PC;
         pc_q      <= RESET_PC;
         valid_q   <= 1'b0;
         instr_q   <= 32'd0;
         id_pc_q   <= 18'd0;
      end else if (ex_if_branch) begin
         pc_q    <= tgt;
         valid_q <= 1'b0;
         // a pending request keeps its address; its response is dropped later
         if (state_q == REQ && !mc_if_valid) begin
            discard_q <= 1'b1;
         end else begin
            state_q   <= REQ;
            en_q      <= 1'b1;
            addr_q    <= tgt;
            discard_q <= 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               en_q    <= 1'b1;
               addr_q  <= pc_q;
            end
            REQ: begin
               if (mc_if_valid && discard_q) begin
                  discard_q <= 1'b0;
                  addr_q    <= pc_q;
               end else if (mc_if_valid) begin
                  instr_q <= mc_if_data;
                  id_pc_q <= addr_q;
                  valid_q <= 1'b1;
                  pc_q    <= addr_q + 18'd4;
                  en_q    <= 1'b0;
                  state_q <= WAIT_ID;
               end
            end
            WAIT_ID: begin
               if (!id_if_stall) begin
                  valid_q <= 1'b0;
                  en_q    <= 1'b1;
                  addr_q  <= pc_q;
                  state_q <= REQ;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
`endif
endmodule
